// File: rtl/cache_requester.sv
// CPU-side cache initiator: queues commands in a small FIFO, issues them one at a
// time to the cache, and returns one response per command (done or timeout).
module cache_requester #(
  parameter int WIDTH      = 8,
  parameter int RAM_DEPTH  = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  localparam int AW        = $clog2(RAM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             we,
  output logic             re,
  output logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data_in,
  input  logic             done,
  input  logic             op_in_progress,
  input  logic [WIDTH-1:0] data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_we,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic [15:0]      ops_done
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int EW   = 1 + AW + WIDTH;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic [EW-1:0]   head;
  logic            head_we;
  logic [AW-1:0]   head_addr;
  logic [WIDTH-1:0] head_data;
  logic            push, pop;
  logic            complete, expire;
  logic            op_we_q;
  logic [TW-1:0]   tmo_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Space is judged from registered occupancy only; a pop this cycle frees nothing yet.
  assign cmd_ready = (count_q != CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;

  assign head      = fifo_mem[rd_ptr];
  assign head_we   = head[EW-1];
  assign head_addr = head[EW-2:WIDTH];
  assign head_data = head[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    complete = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !op_in_progress) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // A done arriving on the last counted cycle still wins over the timeout.
        if (done) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (tmo_q == TLAST) begin
          expire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we          <= 1'b0;
      re          <= 1'b0;
      addr        <= '0;
      data_in     <= '0;
      op_we_q     <= 1'b0;
      tmo_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_we      <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      ops_done    <= '0;
    end else begin
      if (pop) begin
        we      <= head_we;
        re      <= !head_we;
        addr    <= head_addr;
        data_in <= head_data;
        op_we_q <= head_we;
      end
      if (state_q == ISSUE) begin
        we    <= 1'b0;
        re    <= 1'b0;
        tmo_q <= '0;
      end
      if ((state_q == WAIT) && !done) tmo_q <= tmo_q + TW'(1);
      if (complete) begin
        rsp_valid   <= 1'b1;
        rsp_we      <= op_we_q;
        rsp_data    <= op_we_q ? '0 : data_out;
        rsp_timeout <= 1'b0;
        ops_done    <= sat_inc(ops_done);
      end
      if (expire) begin
        rsp_valid   <= 1'b1;
        rsp_we      <= op_we_q;
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
      if ((state_q == RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester: directed scenarios, a behavioural cache, and a
// scoreboard that predicts issue order and responses from the command stream.
module tb_cache_requester;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [7:0] cmd_addr, cmd_data;
  logic       we, re;
  logic [7:0] addr, data_in;
  logic       done, op_in_progress;
  logic [7:0] data_out;
  logic       rsp_valid, rsp_ready, rsp_we, rsp_timeout;
  logic [7:0] rsp_data;
  logic [15:0] ops_done;

  cache_requester #(.WIDTH(8), .RAM_DEPTH(256), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .we(we), .re(re), .addr(addr), .data_in(data_in),
    .done(done), .op_in_progress(op_in_progress), .data_out(data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic w; logic [7:0] a; logic [7:0] d; } cmd_t;
  typedef struct { logic w; logic [7:0] d; logic to; } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  logic [7:0] refmem [256];
  logic [7:0] cmem [256];
  int   exp_ops = 0;
  int   lat = 2;
  logic never_done = 1'b0;

  int   issue_cnt = 0, rsp_cnt = 0, we_cycles = 0, re_cycles = 0, rise_cur = 0;
  int   issue_cyc [64];
  int   rsp_rise_log [64];
  logic [7:0] rsp_log_d [64];
  logic rsp_log_w [64];
  logic rsp_log_to [64];

  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, prev_pulse = 1'b0;
  logic prev_we = 1'b0, prev_to = 1'b0;
  logic [7:0] prev_data = 8'h00;
  cmd_t mon_c;
  rsp_t mon_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_cmd.delete();
      exp_rsp.delete();
      exp_ops = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        mon_c.w = cmd_we; mon_c.a = cmd_addr; mon_c.d = cmd_data;
        exp_cmd.push_back(mon_c);
      end
      check("we_re_exclusive", {31'b0, we & re}, 0);
      if (prev_pulse) check("pulse_one_cycle", {31'b0, we | re}, 0);
      if (we) we_cycles++;
      if (re) re_cycles++;
      if (we || re) begin
        if (exp_cmd.size() == 0) check("issue_unexpected", 1, 0);
        else begin
          mon_c = exp_cmd.pop_front();
          check("issue_kind", {31'b0, we}, {31'b0, mon_c.w});
          check("issue_addr", {24'b0, addr}, {24'b0, mon_c.a});
          if (mon_c.w) check("issue_data", {24'b0, data_in}, {24'b0, mon_c.d});
          if (never_done) begin
            mon_r.w = mon_c.w; mon_r.d = 8'h00; mon_r.to = 1'b1;
          end else if (mon_c.w) begin
            refmem[mon_c.a] = mon_c.d;
            mon_r.w = 1'b1; mon_r.d = 8'h00; mon_r.to = 1'b0;
          end else begin
            mon_r.w = 1'b0; mon_r.d = refmem[mon_c.a]; mon_r.to = 1'b0;
          end
          exp_rsp.push_back(mon_r);
        end
        if (issue_cnt < 64) issue_cyc[issue_cnt] = cyc;
        issue_cnt++;
      end
      if (rsp_valid && !prev_valid) rise_cur = cyc;
      if (prev_valid && !prev_ready && !prev_rst) begin
        check("hold_valid", {31'b0, rsp_valid}, 1);
        check("hold_data", {24'b0, rsp_data}, {24'b0, prev_data});
        check("hold_we", {31'b0, rsp_we}, {31'b0, prev_we});
        check("hold_timeout", {31'b0, rsp_timeout}, {31'b0, prev_to});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          mon_r = exp_rsp.pop_front();
          if (!mon_r.to) exp_ops++;
          check("rsp_we", {31'b0, rsp_we}, {31'b0, mon_r.w});
          check("rsp_data", {24'b0, rsp_data}, {24'b0, mon_r.d});
          check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, mon_r.to});
          check("rsp_ops_done", {16'b0, ops_done}, exp_ops);
        end
        if (rsp_cnt < 64) begin
          rsp_log_d[rsp_cnt] = rsp_data;
          rsp_log_w[rsp_cnt] = rsp_we;
          rsp_log_to[rsp_cnt] = rsp_timeout;
          rsp_rise_log[rsp_cnt] = rise_cur;
        end
        rsp_cnt++;
      end
    end
    prev_valid = rsp_valid; prev_ready = rsp_ready; prev_rst = rst;
    prev_pulse = we | re; prev_we = rsp_we; prev_to = rsp_timeout; prev_data = rsp_data;
  end

  // Behavioural cache: answers each request with done after lat cycles.
  logic       mw;
  logic [7:0] ma, md;
  initial begin
    done = 1'b0;
    data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && (we || re) && !never_done) begin
        mw = we; ma = addr; md = data_in;
        repeat (lat) @(posedge clk);
        #1;
        done = 1'b1;
        if (mw) begin
          cmem[ma] = md;
          data_out = 8'hEE;
        end else data_out = cmem[ma];
        @(posedge clk);
        #1;
        done = 1'b0;
        data_out = 8'h00;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d, output int acc);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
    acc = cyc;
    if (!cmd_ready) check("push_wait", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string name);
    int t;
    t = 0;
    while (rsp_cnt < target && t < 400) begin tick(1); t++; end
    check(name, {31'b0, rsp_cnt >= target}, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n0, n1, br, bi, wc, rc, o, f, t;
  int acc [6];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'h00; cmd_data = 8'h00;
    rsp_ready = 1'b1; op_in_progress = 1'b0;
    for (int i = 0; i < 256; i++) begin refmem[i] = 8'h00; cmem[i] = 8'h00; end
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("rst_we", {31'b0, we}, 0);
    check("rst_re", {31'b0, re}, 0);
    check("rst_addr", {24'b0, addr}, 0);
    check("rst_data_in", {24'b0, data_in}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_rsp_we", {31'b0, rsp_we}, 0);
    check("rst_rsp_data", {24'b0, rsp_data}, 0);
    check("rst_rsp_timeout", {31'b0, rsp_timeout}, 0);
    check("rst_ops_done", {16'b0, ops_done}, 0);
    tick(1);

    // Write then read back, with latency pinned.
    lat = 2; br = rsp_cnt; bi = issue_cnt; wc = we_cycles; rc = re_cycles;
    push(1'b1, 8'h3C, 8'hA5, n0);
    push(1'b0, 8'h3C, 8'h00, n1);
    wait_rsp(br + 2, "t1_rsp_count");
    check("t1_issue_latency", issue_cyc[bi] - n0, 2);
    check("t1_rsp_latency", rsp_rise_log[br] - issue_cyc[bi], 3);
    check("t1_rsp0_we", {31'b0, rsp_log_w[br]}, 1);
    check("t1_rsp0_data", {24'b0, rsp_log_d[br]}, 0);
    check("t1_rsp1_we", {31'b0, rsp_log_w[br+1]}, 0);
    check("t1_rsp1_data", {24'b0, rsp_log_d[br+1]}, 32'hA5);
    check("t1_ops_done", {16'b0, ops_done}, 2);
    check("t1_we_cycles", we_cycles - wc, 1);
    check("t1_re_cycles", re_cycles - rc, 1);

    // FIFO fill under response backpressure.
    lat = 1; rsp_ready = 1'b0; br = rsp_cnt;
    for (int i = 0; i < 5; i++) push(1'b1, 8'h10 + 8'(i), 8'h20 + 8'(i), acc[i]);
    check("t2_back_to_back", acc[4] - acc[0], 4);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h12; cmd_data = 8'h00;
    @(negedge clk);
    check("t2_full_after_5", {31'b0, cmd_ready}, 0);
    tick(4);
    @(negedge clk);
    check("t2_still_full", {31'b0, cmd_ready}, 0);
    check("t2_first_rsp_waiting", {31'b0, rsp_valid}, 1);
    tick(1);
    rsp_ready = 1'b1;
    push(1'b0, 8'h12, 8'h00, acc[5]);
    wait_rsp(br + 6, "t2_rsp_count");
    check("t2_rsp0_we", {31'b0, rsp_log_w[br]}, 1);
    check("t2_sixth_data", {24'b0, rsp_log_d[br+5]}, 32'h22);
    check("t2_ops_done", {16'b0, ops_done}, 8);

    // Held response under backpressure.
    lat = 2; br = rsp_cnt;
    push(1'b1, 8'h11, 8'h5A, n0);
    wait_rsp(br + 1, "t3_wr_rsp");
    rsp_ready = 1'b0; br = rsp_cnt;
    push(1'b0, 8'h11, 8'h00, n0);
    push(1'b0, 8'h10, 8'h00, n1);
    t = 0;
    while (!rsp_valid && t < 100) begin tick(1); t++; end
    check("t3_rsp_seen", {31'b0, rsp_valid}, 1);
    bi = issue_cnt;
    tick(10);
    check("t3_hold_valid", {31'b0, rsp_valid}, 1);
    check("t3_hold_data", {24'b0, rsp_data}, 32'h5A);
    check("t3_no_new_issue", issue_cnt - bi, 0);
    rsp_ready = 1'b1;
    wait_rsp(br + 2, "t3_rsp_count");
    check("t3_second_data", {24'b0, rsp_log_d[br+1]}, 32'h20);

    // Timeout, then recovery.
    never_done = 1'b1; br = rsp_cnt; bi = issue_cnt; o = ops_done;
    push(1'b0, 8'h30, 8'h00, n0);
    wait_rsp(br + 1, "t4_rsp_count");
    check("t4_timeout_cycles", rsp_rise_log[br] - issue_cyc[bi], TO + 1);
    check("t4_timeout_flag", {31'b0, rsp_log_to[br]}, 1);
    check("t4_timeout_data", {24'b0, rsp_log_d[br]}, 0);
    check("t4_ops_unchanged", {16'b0, ops_done}, o);
    never_done = 1'b0;
    push(1'b0, 8'h11, 8'h00, n0);
    wait_rsp(br + 2, "t4_next_rsp");
    check("t4_next_not_timeout", {31'b0, rsp_log_to[br+1]}, 0);
    check("t4_next_data", {24'b0, rsp_log_d[br+1]}, 32'h5A);
    check("t4_ops_after", {16'b0, ops_done}, o + 1);

    // Busy cache holds off issue.
    op_in_progress = 1'b1; br = rsp_cnt; bi = issue_cnt;
    push(1'b0, 8'h13, 8'h00, n0);
    tick(6);
    op_in_progress = 1'b0; f = cyc;
    check("t5_no_issue_while_busy", issue_cnt - bi, 0);
    wait_rsp(br + 1, "t5_rsp_count");
    check("t5_issue_cycle", issue_cyc[bi] - f, 1);
    check("t5_data", {24'b0, rsp_log_d[br]}, 32'h23);

    // Reset in the middle of a wait with three commands queued.
    lat = 20; br = rsp_cnt; bi = issue_cnt;
    push(1'b0, 8'h3C, 8'h00, n0);
    push(1'b0, 8'h10, 8'h00, n0);
    push(1'b0, 8'h11, 8'h00, n0);
    push(1'b0, 8'h12, 8'h00, n0);
    t = 0;
    while (issue_cnt == bi && t < 50) begin tick(1); t++; end
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_cmd_ready", {31'b0, cmd_ready}, 1);
    check("t6_rsp_valid", {31'b0, rsp_valid}, 0);
    check("t6_ops_done", {16'b0, ops_done}, 0);
    check("t6_no_request", {31'b0, we | re}, 0);
    tick(30);
    check("t6_no_late_rsp", rsp_cnt - br, 0);
    check("t6_queue_discarded", issue_cnt - bi, 1);
    check("t6_ops_still_zero", {16'b0, ops_done}, 0);
    lat = 2;
    push(1'b0, 8'h3C, 8'h00, n0);
    wait_rsp(br + 1, "t6_recover_rsp");
    check("t6_recover_data", {24'b0, rsp_log_d[br]}, 32'hA5);
    check("t6_recover_ops", {16'b0, ops_done}, 1);

    tick(2);
    check("end_cmd_queue_empty", exp_cmd.size(), 0);
    check("end_rsp_queue_empty", exp_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_requester.md
Name: cache_requester

Overview:
- CPU-side initiator for the cache request interface: `we`/`re`/`addr`/`data_in` out, `done`/`op_in_progress`/`data_out` in.
- Buffers commands in a small FIFO and issues them to the cache one at a time.
- Waits for `done`, then returns one response per command through a valid/ready port.
- Sits between a test/CPU stimulus source and the cache+RAM top level.

Parameters:
- WIDTH, 8, data word width.
- RAM_DEPTH, 256, address space; address width AW = $clog2(RAM_DEPTH).
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- TIMEOUT, 64, max cycles waiting for `done` before abandoning an op.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_we  in  1  1=write, 0=read.
- cmd_addr  in  AW  command address.
- cmd_data  in  WIDTH  write data (ignored for reads).
- we  out  1  write request to cache.
- re  out  1  read request to cache.
- addr  out  AW  request address.
- data_in  out  WIDTH  write data to cache.
- done  in  1  cache completion pulse; `data_out` valid this cycle for reads.
- op_in_progress  in  1  cache busy.
- data_out  in  WIDTH  cache read data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_we  out  1  response belongs to a write.
- rsp_data  out  WIDTH  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  op abandoned after TIMEOUT.
- ops_done  out  16  count of completed (non-timeout) ops, saturating at 16'hFFFF.

Behaviour:
- Reset: FIFO empty; FSM=IDLE; `cmd_ready`=1; `we`=`re`=0; `addr`=0; `data_in`=0; `rsp_valid`=0; `rsp_we`=0; `rsp_data`=0; `rsp_timeout`=0; `ops_done`=0.
- Reset mid-operation discards the in-flight op, queued commands and any pending response. No output may glitch high in the reset cycle.
- FIFO:
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready` = !full, registered-state based; a same-cycle pop does not free space (no bypass).
  - Pointers wrap modulo FIFO_DEPTH; separate occupancy count 0..FIFO_DEPTH.
  - Push and pop in the same cycle while not full: count unchanged.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if FIFO non-empty and `op_in_progress`=0 → pop head into op registers, go to ISSUE next cycle. Otherwise stay.
  - ISSUE:
    - Exactly one cycle with `we` (write) or `re` (read) =1, plus `addr` and `data_in` driven from op registers.
    - `we` and `re` are never both 1.
    - Go to WAIT; clear timeout counter.
  - WAIT:
    - `we`=`re`=0; `addr`/`data_in` held stable.
    - On `done`=1: capture `data_out` (reads) or 0 (writes) into `rsp_data`, set `rsp_we`, `rsp_timeout`=0, `rsp_valid`=1, increment `ops_done`, go to RESP.
    - Else increment the counter. When it reaches TIMEOUT−1 with no `done`: `rsp_valid`=1, `rsp_timeout`=1, `rsp_data`=0, go to RESP. `ops_done` not incremented.
    - `done` in the same cycle the counter hits TIMEOUT−1 counts as completion, not timeout.
  - RESP: hold all `rsp_*` stable until `rsp_ready`=1; that cycle drop `rsp_valid` and go to IDLE. First issue of the next command is at least one cycle later.
- `done` outside WAIT is ignored (no state change, no counter change).
- Latency: command pushed into an empty FIFO with the cache idle:
  - push in cycle N, pop in N+1, `we`/`re` high in N+2;
  - `done` in cycle N+2+k gives `rsp_valid` in N+3+k.
- Ordering: responses in strict command order; at most one op outstanding.

Test Plan:
- Write then read: push {we=1, addr=8'h3C, data=8'hA5}, then {we=0, addr=8'h3C}, `rsp_ready`=1 → two responses: {rsp_we=1, rsp_data=0}, then {rsp_we=0, rsp_data=8'hA5}; `ops_done`=2; `we`/`re` each high exactly one cycle.
- FIFO full: `rsp_ready`=0, push 6 commands back-to-back → `cmd_ready` drops after the 5th accepted (4 queued + 1 in flight). Releasing `rsp_ready` drains all 5 in order; the 6th is accepted once `cmd_ready` rises.
- Backpressure: hold `rsp_ready`=0 for 10 cycles after a read of 8'h11 → `rsp_valid`/`rsp_data` stable; no new `re` pulse until after the handshake.
- Timeout: cache model never asserts `done` → `rsp_timeout`=1, `rsp_data`=0 after exactly TIMEOUT cycles in WAIT; `ops_done` unchanged; the next command still issues.
- Busy cache: `op_in_progress`=1 for 7 cycles with a queued command → no `we`/`re` until the cycle after it falls, plus one ISSUE cycle.
- Reset mid-WAIT with 3 commands queued → next cycle: `cmd_ready`=1, `rsp_valid`=0, `ops_done`=0; a late `done` is ignored.
